// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the stream multiplexer slice.
//   ARB_SEL / ARB_RR : arbitration mode codes for the ARB_MODE parameter
//   sel_width()      : width of a channel index, at least one bit
package stream_mux_n_pkg;

    localparam int ARB_SEL = 0;
    localparam int ARB_RR  = 1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Rotating-priority arbiter, purely combinational.
// Ports:
//   req       : per-channel request
//   ptr       : highest-priority channel this cycle (always < CHANNELS)
//   gnt_valid : at least one request present
//   gnt_idx   : first requesting channel at or cyclically after ptr
module rr_arbiter
    import stream_mux_n_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    // Walk offsets from the far end down to zero so the candidate closest
    // to ptr is the last one written and therefore wins.
    always_comb begin
        int               pos;
        logic [SEL_W-1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= CHANNELS) begin
                pos = pos - CHANNELS;
            end
            cand = SEL_W'(pos);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input registered stream multiplexer with valid/ready on every channel.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   sel               : channel select (select-driven mode only)
//   in_valid/in_data  : producer channels, channel k at in_data[k*WIDTH +: WIDTH]
//   in_ready          : per-channel ready, combinational, at most one set
//   out_valid/out_data/out_chan : registered output word and its source channel
//   out_ready         : consumer accepts the output word
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  CHANNELS = 4,
    parameter int  ARB_MODE = ARB_SEL,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    logic             can_load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] rr_ptr;
    logic             transfer;
    logic [WIDTH-1:0] grant_data;

    // out_ready reaches in_ready combinationally so a full register can be
    // drained and refilled in the same cycle.
    assign can_load = !out_valid || out_ready;

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;
            rr_arbiter #(
                .CHANNELS (CHANNELS),
                .SEL_W    (SEL_W)
            ) u_arb (
                .req       (in_valid),
                .ptr       (rr_ptr),
                .gnt_valid (grant_valid),
                .gnt_idx   (grant_idx)
            );
        end else begin : g_sel
            logic unused_ptr;
            assign unused_ptr  = ^rr_ptr;
            // Codes above CHANNELS-1 exist when CHANNELS is not a power of two.
            assign grant_valid = (int'(sel) < CHANNELS);
            assign grant_idx   = sel;
        end
    endgenerate

    // Decoded by loop rather than a variable part-select so an unused select
    // code never addresses beyond the packed input bus.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                in_ready[k] = rst_n && can_load && grant_valid;
                grant_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = |(in_ready & in_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (can_load) begin
                out_valid <= transfer;
                if (transfer) begin
                    out_data <= grant_data;
                    out_chan <= grant_idx;
                end
            end
            if (transfer && (ARB_MODE == ARB_RR)) begin
                rr_ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0
                                                              : grant_idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // select-driven, 4 channels
    logic [1:0]  sel0;
    logic [3:0]  iv0, ir0;
    logic [31:0] id0;
    logic        ov0, ordy0;
    logic [7:0]  od0;
    logic [1:0]  oc0;

    // select-driven, 3 channels
    logic [1:0]  sel3;
    logic [2:0]  iv3, ir3;
    logic [23:0] id3;
    logic        ov3, ordy3;
    logic [7:0]  od3;
    logic [1:0]  oc3;

    // round-robin, 4 channels
    logic [1:0]  selr;
    logic [3:0]  ivr, irr;
    logic [31:0] idr;
    logic        ovr, ordyr;
    logic [7:0]  odr;
    logic [1:0]  ocr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    stream_mux_n #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .in_valid(iv0), .in_data(id0),
        .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_chan(oc0), .out_ready(ordy0));

    stream_mux_n #(.WIDTH(8), .CHANNELS(3), .ARB_MODE(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel3), .in_valid(iv3), .in_data(id3),
        .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_chan(oc3), .out_ready(ordy3));

    stream_mux_n #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(1)) dutr (
        .clk(clk), .rst_n(rst_n), .sel(selr), .in_valid(ivr), .in_data(idr),
        .in_ready(irr), .out_valid(ovr), .out_data(odr), .out_chan(ocr), .out_ready(ordyr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel0 = 2'd0; iv0 = 4'hF; id0 = 32'h44332211; ordy0 = 1'b1;
        sel3 = 2'd0; iv3 = 3'h7; id3 = 24'h332211;   ordy3 = 1'b1;
        selr = 2'd0; ivr = 4'hF; idr = 32'h44332211; ordyr = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if ({ir0, ir3, irr} !== 11'd0)
                $display("FAIL reset_in_ready cyc%0d: got %b/%b/%b expected 0", c, ir0, ir3, irr);
            else pass_cnt++;
            if (c < 2) tick();
        end
        total_cnt++;
        if (ov0 !== 1'b0 || od0 !== 8'h00 || oc0 !== 2'd0)
            $display("FAIL reset_out0: got v=%b d=%h c=%0d expected 0/00/0", ov0, od0, oc0);
        else pass_cnt++;
        total_cnt++;
        if (ov3 !== 1'b0 || od3 !== 8'h00 || oc3 !== 2'd0 || ovr !== 1'b0 || odr !== 8'h00 || ocr !== 2'd0)
            $display("FAIL reset_out3r: got v=%b/%b d=%h/%h c=%0d/%0d expected 0", ov3, ovr, od3, odr, oc3, ocr);
        else pass_cnt++;
        iv0 = 4'h0; iv3 = 3'h0; ivr = 4'h0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mode0_basic();
        sel0 = 2'd2; iv0 = 4'b0100; id0 = 32'h00A50000; ordy0 = 1'b1;
        #1;
        total_cnt++;
        if (ir0 !== 4'b0100) $display("FAIL m0_ready: got %b expected 0100", ir0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ov0 !== 1'b1 || od0 !== 8'hA5 || oc0 !== 2'd2)
            $display("FAIL m0_out: got v=%b d=%h c=%0d expected 1/a5/2", ov0, od0, oc0);
        else pass_cnt++;
        iv0 = 4'b0000;
        tick();
        total_cnt++;
        if (ov0 !== 1'b0 || od0 !== 8'hA5)
            $display("FAIL m0_drop: got v=%b d=%h expected 0/a5", ov0, od0);
        else pass_cnt++;
        // grant follows sel even when another channel is the one offering
        sel0 = 2'd1; iv0 = 4'b0100;
        #1;
        total_cnt++;
        if (ir0 !== 4'b0010) $display("FAIL m0_sel_only: got %b expected 0010", ir0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ov0 !== 1'b0) $display("FAIL m0_no_xfer: got v=%b expected 0", ov0);
        else pass_cnt++;
        sel0 = 2'd2;
        iv0 = 4'b0000;
    endtask

    task automatic test_backpressure();
        sel0 = 2'd2; iv0 = 4'b0100; id0 = 32'h00A50000; ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0; id0 = 32'h003C0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if (ir0 !== 4'b0000 || ov0 !== 1'b1 || od0 !== 8'hA5)
                $display("FAIL bp_hold cyc%0d: got r=%b v=%b d=%h expected 0000/1/a5", c, ir0, ov0, od0);
            else pass_cnt++;
            @(posedge clk);
        end
        #1;
        ordy0 = 1'b1;
        #1;
        total_cnt++;
        if (ir0 !== 4'b0100) $display("FAIL bp_release_ready: got %b expected 0100", ir0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ov0 !== 1'b1 || od0 !== 8'h3C || oc0 !== 2'd2)
            $display("FAIL bp_release_out: got v=%b d=%h c=%0d expected 1/3c/2", ov0, od0, oc0);
        else pass_cnt++;
        iv0 = 4'b0000;
        tick();
        total_cnt++;
        if (ov0 !== 1'b0) $display("FAIL bp_drain: got v=%b expected 0", ov0);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd1; iv3 = 3'b111; id3 = 24'h332211; ordy3 = 1'b1;
        tick();
        total_cnt++;
        if (ov3 !== 1'b1 || od3 !== 8'h22 || oc3 !== 2'd1)
            $display("FAIL oor_load: got v=%b d=%h c=%0d expected 1/22/1", ov3, od3, oc3);
        else pass_cnt++;
        sel3 = 2'd3;
        #1;
        total_cnt++;
        if (ir3 !== 3'b000) $display("FAIL oor_ready: got %b expected 000", ir3);
        else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++;
            if (ov3 !== 1'b0 || ir3 !== 3'b000 || od3 !== 8'h22)
                $display("FAIL oor_drain cyc%0d: got v=%b r=%b d=%h expected 0/000/22", c, ov3, ir3, od3);
            else pass_cnt++;
        end
        sel3 = 2'd2;
        #1;
        total_cnt++;
        if (ir3 !== 3'b100) $display("FAIL oor_top_ready: got %b expected 100", ir3);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ov3 !== 1'b1 || od3 !== 8'h33 || oc3 !== 2'd2)
            $display("FAIL oor_top_out: got v=%b d=%h c=%0d expected 1/33/2", ov3, od3, oc3);
        else pass_cnt++;
        iv3 = 3'b000;
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_chan [6];
        logic [7:0] exp_data [4];
        exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_data = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        selr = 2'd3;   // ignored in round-robin mode
        ivr = 4'hF; idr = 32'hD3C2B1A0; ordyr = 1'b1;
        #1;
        total_cnt++;
        if (irr !== 4'b0001) $display("FAIL rr_first_ready: got %b expected 0001", irr);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if (ovr !== 1'b1 || ocr !== exp_chan[i] || odr !== exp_data[exp_chan[i]])
                $display("FAIL rr_fair[%0d]: got v=%b c=%0d d=%h expected 1/%0d/%h",
                         i, ovr, ocr, odr, exp_chan[i], exp_data[exp_chan[i]]);
            else pass_cnt++;
        end
        ivr = 4'h0;
    endtask

    task automatic test_rr_sparse_reset();
        logic [1:0] exp_chan [5];
        exp_chan = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        // restart from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ivr = 4'b1010; idr = 32'hD3C2B1A0; ordyr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (ovr !== 1'b1 || ocr !== exp_chan[i])
                $display("FAIL rr_sparse[%0d]: got v=%b c=%0d expected 1/%0d", i, ovr, ocr, exp_chan[i]);
            else pass_cnt++;
        end
        // pointer now sits at 2; without a reset the next grant would be ch3
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (irr !== 4'b0000) $display("FAIL rr_rst_ready: got %b expected 0000", irr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ovr !== 1'b0) $display("FAIL rr_rst_out: got v=%b expected 0", ovr);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (irr !== 4'b0010) $display("FAIL rr_post_rst_ready: got %b expected 0010", irr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ovr !== 1'b1 || ocr !== 2'd1 || odr !== 8'hB1)
            $display("FAIL rr_post_rst_out: got v=%b c=%0d d=%h expected 1/1/b1", ovr, ocr, odr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ovr !== 1'b1 || ocr !== 2'd3 || odr !== 8'hD3)
            $display("FAIL rr_post_rst_next: got v=%b c=%0d d=%h expected 1/3/d3", ovr, ocr, odr);
        else pass_cnt++;
        ivr = 4'h0;
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_backpressure();
        test_out_of_range();
        test_rr_fairness();
        test_rr_sparse_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
